// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame receiver.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // The bit counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchronizer of configurable depth, cleared by synchronous reset.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 peripheral receiver with single-entry output register and overrun flag.
// Optional transmit path enabled by defining SPI_FRAME_TX_EN.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             sdi,
  input  logic             nss,
  output logic             sdo,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             overrun,
  output logic             frame_err,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic sck_s, sdi_s, nss_s;
  logic sck_q, nss_q;
  logic sck_rise, nss_fall, nss_rise;
  logic frame_done;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] rx_sr;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst(rst), .d(sck), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (.clk(clk), .rst(rst), .d(sdi), .q(sdi_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (.clk(clk), .rst(rst), .d(nss), .q(nss_s));

  assign sck_rise   = sck_s & ~sck_q;
  assign nss_fall   = ~nss_s & nss_q;
  assign nss_rise   = nss_s & ~nss_q;
  assign frame_done = (cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      rx_sr     <= '0;
      sck_q     <= 1'b0;
      nss_q     <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sck_q     <= sck_s;
      nss_q     <= nss_s;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (nss_fall) begin
            state <= ACTIVE;
            busy  <= 1'b1;
            cnt   <= '0;
            rx_sr <= '0;
          end
        end
        ACTIVE: begin
          if (nss_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            rx_sr     <= '0;
            frame_err <= (cnt != '0) && !frame_done;
          end else if (frame_done) begin
            cnt <= '0;
          end else if (sck_rise) begin
            rx_sr <= {rx_sr[WIDTH-2:0], sdi_s};
            cnt   <= cnt + 1'b1;
          end
        end
      endcase

      // A completing frame wins over a bare acknowledge; a coincident ack frees the slot.
      if (frame_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
          overrun  <= 1'b0;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_TX_EN
  logic [WIDTH-1:0] tx_sr;
  logic             skip_fall;
  logic             sck_fall;

  assign sck_fall = ~sck_s & sck_q;

  // The sck fall right after a frame's last bit must not shift the freshly reloaded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr     <= '0;
      skip_fall <= 1'b0;
    end else if (state == IDLE) begin
      if (nss_fall) tx_sr <= tx_data;
      skip_fall <= 1'b0;
    end else if (frame_done) begin
      tx_sr     <= tx_data;
      skip_fall <= 1'b1;
    end else if (sck_fall) begin
      if (skip_fall) skip_fall <= 1'b0;
      else           tx_sr     <= {tx_sr[WIDTH-2:0], 1'b0};
    end
  end

  assign sdo = busy & tx_sr[WIDTH-1];
`else
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign sdo       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed table, corner sequences, randomized frames vs. a transaction model.
module tb_spi_frame_rx;

  localparam int WIDTH = 16;
  localparam int SS    = 2;

  logic             clk = 1'b0;
  logic             rst, sck, sdi, nss, sdo;
  logic             rx_valid, rx_ack, overrun, frame_err, busy;
  logic [WIDTH-1:0] rx_data, tx_data;

  always #5 clk = ~clk;

  spi_frame_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .nss(nss), .sdo(sdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .overrun(overrun),
    .frame_err(frame_err), .tx_data(tx_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int sdo_ones = 0;
  logic [63:0] sdo_log = '0;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (sdo) sdo_ones++;
  end

  // Transaction-level expectation of the receive register.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ovr;
  int               m_fe;

  typedef struct {
    logic             ack_before;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ovr;
  } vec_t;
  vec_t tbl[4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_done(input logic [WIDTH-1:0] w, input bit ack);
    if (!m_valid || ack) begin
      m_data  = w;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Shifts n bits MSB first; lat = clk edges from final sck rise until rx_valid rises.
  task automatic send_bits(input logic [31:0] w, input int n, input bit ack_done, output int lat);
    logic vb;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      sdi = w[n-1-i];
      tick(4);
      sdo_log = {sdo_log[62:0], sdo};
      vb  = rx_valid;
      sck = 1'b1;
      if (i == n - 1) begin
        for (int k = 1; k <= 8; k++) begin
          tick(1);
          if (!vb && lat < 0 && rx_valid) lat = k;
          if (ack_done && k == SS + 1) rx_ack = 1'b1;
          if (ack_done && k == SS + 2) rx_ack = 1'b0;
        end
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic frame_end();
    sck = 1'b0;
    tick(4);
    nss = 1'b1;
    tick(8);
  endtask

  task automatic full_frame(input logic [WIDTH-1:0] w, input bit ack_done, output int lat);
    nss = 1'b0;
    tick(6);
    send_bits({16'h0, w}, WIDTH, ack_done, lat);
    model_done(w, ack_done);
    frame_end();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, rx_valid, m_valid);
    chk({tag, "_data"}, rx_data, m_data);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_ferr"}, fe_cnt, m_fe);
  endtask

  initial begin
    int lat;
    int n;
    logic [WIDTH-1:0] w1, w2;

    tbl[0] = '{1'b0, 16'hA5C3, 16'hA5C3, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h5678, 16'h1234, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0};

    rst = 1'b1; sck = 1'b0; sdi = 1'b0; nss = 1'b1; rx_ack = 1'b0; tx_data = 16'h8001;
    m_valid = 1'b0; m_data = '0; m_ovr = 1'b0; m_fe = 0;
    tick(4);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(6);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].ack_before) ack_pulse();
      full_frame(tbl[i].data, 1'b0, lat);
      chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].exp_ovr);
      if (i == 0) chk("latency", lat, SS + 2);
    end

    // Overrun then acknowledge clears both flags.
    full_frame(16'h2222, 1'b0, lat);
    chk("ovr_set", overrun, 1);
    ack_pulse();
    chk("ack_valid", rx_valid, 0);
    chk("ack_ovr", overrun, 0);

    // Acknowledge coincident with completion, starting from an overrun.
    full_frame(16'h1111, 1'b0, lat);
    full_frame(16'h2222, 1'b0, lat);
    full_frame(16'hBEEF, 1'b1, lat);
    check_state("coinc");
    chk("coinc_data_lit", rx_data, 16'hBEEF);

    // Partial frame: single frame_err pulse, output register untouched.
    nss = 1'b0;
    tick(6);
    chk("busy_active", busy, 1);
    send_bits(32'h5A, 7, 1'b0, lat);
    frame_end();
    m_fe++;
    check_state("partial");
    chk("idle_busy", busy, 0);
    ack_pulse();
    full_frame(16'h3C5A, 1'b0, lat);
    check_state("after_partial");

    // Reset mid-frame, then keep clocking with nss still low: nothing may be captured.
    ack_pulse();
    nss = 1'b0;
    tick(6);
    send_bits(32'h1FF, 9, 1'b0, lat);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
    send_bits(32'h7F, 7, 1'b0, lat);
    chk("rst_mid_busy", busy, 0);
    frame_end();
    check_state("rst_mid");
    full_frame(16'h00FF, 1'b0, lat);
    check_state("rst_after");

    for (int r = 0; r < 20; r++) begin
      tx_data = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          full_frame(16'($urandom), 1'($urandom_range(0, 1)), lat);
        end
        1: ack_pulse();
        2: begin
          n = $urandom_range(1, WIDTH - 1);
          nss = 1'b0;
          tick(6);
          send_bits($urandom, n, 1'b0, lat);
          frame_end();
          m_fe++;
        end
        default: begin
          w1 = 16'($urandom);
          w2 = 16'($urandom);
          nss = 1'b0;
          tick(6);
          send_bits({w1, w2}, 2 * WIDTH, 1'b0, lat);
          model_done(w1, 1'b0);
          model_done(w2, 1'b0);
          frame_end();
        end
      endcase
      check_state($sformatf("rnd%0d", r));
    end

`ifdef SPI_FRAME_TX_EN
    tx_data = 16'h8001;
    ack_pulse();
    nss = 1'b0;
    tick(6);
    sdo_log = '0;
    send_bits(32'h1357_9BDF, 2 * WIDTH, 1'b0, lat);
    model_done(16'h1357, 1'b0);
    model_done(16'h9BDF, 1'b0);
    frame_end();
    chk("tx_sdo", sdo_log[31:0], 32'h8001_8001);
    chk("tx_idle_sdo", sdo, 0);
    check_state("tx_frames");
`else
    chk("sdo_const0", sdo_ones, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning SPI frame length in bits (legal 2..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for sck/sdi/nss (legal 2..3).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset: rst, synchronous, active-high.
REQ-005 The block SHALL have port sck  input  1  SPI clock from controller, asynchronous to clk.
REQ-006 The block SHALL have port sdi  input  1  SPI serial data in, MSB first.
REQ-007 The block SHALL have port nss  input  1  SPI select, active-low.
REQ-008 The block SHALL have port sdo  output  1  SPI serial data out, MSB first.
REQ-009 The block SHALL have port rx_data  output  WIDTH  last completed frame.
REQ-010 The block SHALL have port rx_valid  output  1  rx_data holds an unacknowledged frame.
REQ-011 The block SHALL have port rx_ack  input  1  consumer has taken rx_data.
REQ-012 The block SHALL have port overrun  output  1  sticky: a frame was dropped while rx_valid was high.
REQ-013 The block SHALL have port frame_err  output  1  one-clk pulse: nss deasserted mid-frame.
REQ-014 The block SHALL have port tx_data  input  WIDTH  word to transmit in the next frame.
REQ-015 The block SHALL have port busy  output  1  high in state ACTIVE.

Function
REQ-016 The block SHALL synchronize sck, sdi and nss through SYNC_STAGES flops each and detect sck rise/fall from the synchronized value; clk SHALL be >= 4x sck frequency.
REQ-017 The block SHALL implement SPI mode 0: sample sdi on sck rise, update sdo on sck fall.
REQ-018 The FSM SHALL have states IDLE (nss high) and ACTIVE (nss low); IDLE->ACTIVE on synchronized nss fall, ACTIVE->IDLE on synchronized nss rise.
REQ-019 On IDLE->ACTIVE the block SHALL clear the bit counter and load tx_data into the TX shift register.
REQ-020 In ACTIVE each detected sck rise SHALL shift sdi into the RX shift register LSB and increment the bit counter.
REQ-021 When the counter reaches WIDTH the block SHALL complete the frame, reset the counter to 0 and reload tx_data, permitting back-to-back frames under one nss low.
REQ-022 rx_valid SHALL rise exactly SYNC_STAGES+2 clk edges after the sck rise sampling the final bit.
REQ-023 On completion with rx_valid low, rx_data SHALL load the frame and rx_valid SHALL set.
REQ-024 On completion with rx_valid high and rx_ack low, the frame SHALL be discarded, rx_data retained and overrun set.
REQ-025 On completion and rx_ack in the same cycle, the new frame SHALL load, rx_valid SHALL stay high, and overrun SHALL not set.
REQ-026 rx_ack with rx_valid high SHALL clear rx_valid and overrun next cycle; rx_ack with rx_valid low SHALL be ignored.
REQ-027 nss rise with counter nonzero SHALL discard the partial frame and pulse frame_err for one clk.
REQ-028 sck edges in IDLE SHALL be ignored.

Reset
REQ-029 While rst is high the FSM SHALL enter IDLE, and counter, shift registers, synchronizers, rx_data, rx_valid, overrun, frame_err, busy and sdo SHALL be 0.
REQ-030 Reset mid-frame SHALL abandon the frame without frame_err; the next frame SHALL start only at a fresh nss fall after rst deasserts.

Configuration
REQ-031 With SPI_FRAME_TX_EN defined, sdo SHALL drive the TX shift register MSB, advancing on each sck fall in ACTIVE, 0 in IDLE.
REQ-032 Without SPI_FRAME_TX_EN, sdo SHALL be constant 0, tx_data unused, and no TX register SHALL be built.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum (IDLE, ACTIVE) and the counter-width function clog2(WIDTH+1).
REQ-034 Synchronization SHALL be a sub-module spi_sync (parametrised depth, 1-bit), instantiated three times.

Verification
REQ-035 WIDTH=16, send 0xA5C3, no ack -> rx_data=0xA5C3, rx_valid=1 at SYNC_STAGES+2 clk after last sck rise.
REQ-036 Send 0x1234 then 0x5678 without ack -> rx_data=0x1234, overrun=1; rx_ack -> rx_valid=0, overrun=0.
REQ-037 Ack coincident with completion of second frame 0xBEEF -> rx_data=0xBEEF, rx_valid=1, overrun=0.
REQ-038 nss rises after 7 bits -> frame_err one-clk pulse, rx_valid unchanged, counter 0.
REQ-039 SPI_FRAME_TX_EN, tx_data=0x8001, two frames under one nss -> sdo emits 1,0x14,1 twice.
REQ-040 rst asserted after 9 bits, then full frame 0x00FF -> no frame_err, rx_data=0x00FF.
